// File: rtl/atm_frame_writer.sv
// Frame-atomic FWFT FIFO for tagged ADC results on SAMPLE_CLK; readers only ever see whole frames.
// Optional even-parity bit on each stored word when ATMFW_PARITY_EN is defined.
module atm_frame_writer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              SAMPLE_CLK,
    input  logic              NRST_sync,
    input  logic              ENSAMP_sync,
    input  logic              ADC_DONE,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic [7:0]        ATMCHSEL_DATA,
    input  logic              LASTWORD,
    input  logic              RD_EN,
`ifdef ATMFW_PARITY_EN
    output logic [DATA_W+4:0] RD_DATA,
`else
    output logic [DATA_W+3:0] RD_DATA,
`endif
    output logic              RD_VALID,
    output logic [ADDR_W:0]   FIFO_LEVEL,
    output logic [7:0]        FRAME_CNT,
    output logic              OVERFLOW,
    output logic              CHERR
);

`ifdef ATMFW_PARITY_EN
    localparam int WORD_W = DATA_W + 5;
`else
    localparam int WORD_W = DATA_W + 4;
`endif

    typedef logic [ADDR_W:0] ptr_t;
    typedef enum logic [1:0] {IDLE, RUN, DISCARD} state_t;

    state_t            state, state_nxt;
    ptr_t              wr_ptr, cm_ptr, rd_ptr;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [2:0]        ch;
    logic              chsel_ok, full, pop;
    logic              do_write, do_commit, do_rewind, set_ovf, set_cherr;

    always_comb begin
        ch = '0;
        for (int i = 0; i < 8; i++)
            if (ATMCHSEL_DATA[i]) ch = 3'(i);
    end

    assign chsel_ok = (ATMCHSEL_DATA != 8'd0) &&
                      ((ATMCHSEL_DATA & (ATMCHSEL_DATA - 8'd1)) == 8'd0);

`ifdef ATMFW_PARITY_EN
    assign wr_word = {^{LASTWORD, ch, ADC_DATA}, LASTWORD, ch, ADC_DATA};
`else
    assign wr_word = {LASTWORD, ch, ADC_DATA};
`endif

    // Space is judged against the registered read pointer, so a same-cycle pop does not rescue a push.
    assign full       = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
    assign RD_VALID   = (cm_ptr != rd_ptr);
    assign FIFO_LEVEL = cm_ptr - rd_ptr;
    assign pop        = RD_EN && RD_VALID;
    assign RD_DATA    = RD_VALID ? mem[rd_ptr[ADDR_W-1:0]] : '0;

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_rewind = 1'b0;
        set_ovf   = 1'b0;
        set_cherr = 1'b0;
        case (state)
            IDLE: begin
                do_rewind = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (ADC_DONE) begin
                    if (!chsel_ok || full) begin
                        set_cherr = !chsel_ok;
                        set_ovf   = full;
                        do_rewind = 1'b1;
                        state_nxt = LASTWORD ? RUN : DISCARD;
                    end else begin
                        do_write  = 1'b1;
                        do_commit = LASTWORD;
                    end
                end
            end
            DISCARD: begin
                if (ADC_DONE && LASTWORD) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
        // Leaving sampling wins over everything, including a DONE in the same cycle.
        if (!ENSAMP_sync) begin
            state_nxt = IDLE;
            do_write  = 1'b0;
            do_commit = 1'b0;
            set_ovf   = 1'b0;
            set_cherr = 1'b0;
            do_rewind = (state == IDLE);
        end
    end

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            FRAME_CNT <= '0;
            OVERFLOW  <= 1'b0;
            CHERR     <= 1'b0;
        end else begin
            if (do_write)       wr_ptr <= wr_ptr + ptr_t'(1);
            else if (do_rewind) wr_ptr <= cm_ptr;
            if (do_commit) begin
                cm_ptr    <= wr_ptr + ptr_t'(1);
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end
            if (pop)       rd_ptr   <= rd_ptr + ptr_t'(1);
            if (set_ovf)   OVERFLOW <= 1'b1;
            if (set_cherr) CHERR    <= 1'b1;
        end
    end

    always_ff @(posedge SAMPLE_CLK) begin
        if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
    end

endmodule

// File: tb/tb_atm_frame_writer.sv
// Directed bench for atm_frame_writer: frame commit, overflow, channel errors, disable, reset, parity.
module tb_atm_frame_writer;

`ifdef ATMFW_PARITY_EN
    localparam int RW = 21;
`else
    localparam int RW = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n, ensamp, done, last, rd_en;
    logic [15:0]   adc_data;
    logic [7:0]    chsel;
    logic [RW-1:0] rd_data;
    logic          rd_valid, ovf, cherr;
    logic [4:0]    level;
    logic [7:0]    frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    atm_frame_writer dut (
        .SAMPLE_CLK(clk), .NRST_sync(rst_n), .ENSAMP_sync(ensamp), .ADC_DONE(done),
        .ADC_DATA(adc_data), .ATMCHSEL_DATA(chsel), .LASTWORD(last), .RD_EN(rd_en),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .FIFO_LEVEL(level), .FRAME_CNT(frame_cnt),
        .OVERFLOW(ovf), .CHERR(cherr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ensamp = 1'b0; done = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enable();
        ensamp = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] sel, input logic [15:0] d, input logic l);
        done = 1'b1; chsel = sel; adc_data = d; last = l;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, 32'(rd_data), exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        chsel = '0; adc_data = '0; last = 1'b0;
        do_reset();
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_fcnt", 32'(frame_cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cherr", 32'(cherr), 0);
        chk("rst_data", 32'(rd_data), 0);

        // two-word frame; the last flag is bit 19, so the closing ch2 word reads 0xAABCD
        enable();
        push(8'h01, 16'h1234, 1'b0);
        chk("t1_uncommitted", 32'(rd_valid), 0);
        push(8'h04, 16'hABCD, 1'b1);
        chk("t1_valid", 32'(rd_valid), 1);
        chk("t1_level", 32'(level), 2);
        chk("t1_fcnt", 32'(frame_cnt), 1);
        pop_chk("t1_rd0", 32'h01234);
        pop_chk("t1_rd1", 32'hAABCD);
        chk("t1_empty", 32'(rd_valid), 0);

        // overflow: fill with two 8-word frames, third frame dropped whole
        do_reset();
        enable();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) push(8'h01 << i, 16'(i), i == 7);
        chk("t2_full_level", 32'(level), 16);
        chk("t2_fcnt2", 32'(frame_cnt), 2);
        push(8'h01, 16'hDEAD, 1'b0);
        chk("t2_ovf", 32'(ovf), 1);
        for (int i = 1; i < 8; i++) push(8'h01 << i, 16'hBEEF, i == 7);
        chk("t2_level_kept", 32'(level), 16);
        chk("t2_fcnt_kept", 32'(frame_cnt), 2);
        for (int i = 0; i < 16; i++)
            pop_chk("t2_drain", {12'd0, (i % 8) == 7, 3'(i % 8), 16'(i % 8)});
        chk("t2_drained", 32'(level), 0);
        push(8'h01, 16'h0100, 1'b0);
        push(8'h02, 16'h0200, 1'b1);
        chk("t2_fcnt3", 32'(frame_cnt), 3);
        chk("t2_level2", 32'(level), 2);
        chk("t2_ovf_sticky", 32'(ovf), 1);

        // corrupt channel select kills the frame, next frame clean
        do_reset();
        enable();
        push(8'h02, 16'h0011, 1'b0);
        push(8'h03, 16'h0022, 1'b0);
        chk("t3_cherr", 32'(cherr), 1);
        push(8'h10, 16'h0033, 1'b1);
        chk("t3_hidden", 32'(rd_valid), 0);
        push(8'h20, 16'h0055, 1'b1);
        chk("t3_level", 32'(level), 1);
        chk("t3_fcnt", 32'(frame_cnt), 1);
        chk("t3_ovf_clear", 32'(ovf), 0);
        pop_chk("t3_rd", 32'hD0055);

        // disable mid-frame discards the partial frame and the same-cycle DONE
        do_reset();
        enable();
        push(8'h04, 16'h0022, 1'b1);
        for (int i = 0; i < 3; i++) push(8'h01, 16'hFFFF, 1'b0);
        ensamp = 1'b0;
        push(8'h80, 16'h0077, 1'b1);
        repeat (2) @(negedge clk);
        chk("t4_level_kept", 32'(level), 1);
        chk("t4_fcnt_kept", 32'(frame_cnt), 1);
        enable();
        push(8'h08, 16'h0033, 1'b0);
        push(8'h40, 16'h0066, 1'b1);
        chk("t4_level", 32'(level), 3);
        pop_chk("t4_rd0", 32'hA0022);
        pop_chk("t4_rd1", 32'h30033);
        pop_chk("t4_rd2", 32'hE0066);

        // asynchronous reset mid-frame, then reads on an empty FIFO
        do_reset();
        enable();
        for (int i = 0; i < 5; i++) push(8'h01 << i, 16'h0050 + 16'(i), i == 4);
        chk("t5_level5", 32'(level), 5);
        push(8'h01, 16'h0001, 1'b0);
        push(8'h02, 16'h0002, 1'b0);
        #2 rst_n = 1'b0; ensamp = 1'b0;
        #1;
        chk("t5_async_valid", 32'(rd_valid), 0);
        chk("t5_async_level", 32'(level), 0);
        chk("t5_async_fcnt", 32'(frame_cnt), 0);
        chk("t5_async_data", 32'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        chk("t5_empty_pop_level", 32'(level), 0);
        chk("t5_empty_pop_valid", 32'(rd_valid), 0);
        enable();
        push(8'h02, 16'h0099, 1'b1);
        chk("t5_level1", 32'(level), 1);
        pop_chk("t5_rd", 32'h90099);
        chk("t5_level0", 32'(level), 0);

`ifdef ATMFW_PARITY_EN
        do_reset();
        enable();
        push(8'h02, 16'h0001, 1'b0);
        push(8'h01, 16'h0001, 1'b0);
        push(8'h80, 16'h0000, 1'b1);
        pop_chk("t6_par0", 32'h010001);
        pop_chk("t6_par1", 32'h100001);
        pop_chk("t6_par_last", 32'h0F0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
